// File: rtl/cia_interval_timer.sv
// cia_interval_timer
// 16-bit CIA-style interval timer with a byte-wide register port.
// It counts E-clock ticks or external CNT pulses. On underflow it reloads
// from the latch and raises a sticky interrupt flag.
// All activity is qualified by clk7_en; between enables all state holds.
//
// Ports:
//   clk_28    28 MHz clock; all state changes on its rising edge
//   rst       synchronous active-high reset
//   clk7_en   7 MHz enable that marks the active cycles
//   eclk_tick E-clock count qualifier (INMODE=0)
//   cnt_in    external count pulse (INMODE=1), already synchronised
//   sel/we/addr/din  register access: 0 TLO, 1 THI, 2 CTRL, 3 ICR
//   dout      registered read data, updated only by reads
//   irq       sticky underflow flag, cleared by an ICR read
//   uf_pulse  underflow strobe, one active cycle wide
module cia_interval_timer #(
   parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
   input  logic       clk_28,
   input  logic       rst,
   input  logic       clk7_en,
   input  logic       eclk_tick,
   input  logic       cnt_in,
   input  logic       sel,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   output logic       uf_pulse
);

   localparam logic [1:0] A_TLO  = 2'd0;
   localparam logic [1:0] A_THI  = 2'd1;
   localparam logic [1:0] A_CTRL = 2'd2;
   localparam logic [1:0] A_ICR  = 2'd3;

   logic [15:0] latch_q, latch_d;
   logic [15:0] cnt_q, cnt_d;
   logic        start_q, start_d;
   logic        runmode_q, runmode_d;
   logic        inmode_q, inmode_d;
   logic        irq_q, irq_d;
   logic        uf_q, uf_d;
   logic [7:0]  dout_q, dout_d;

   logic wr, rd, tick, uf, thi_wr, thi_load, force_load;

   always_comb begin
      latch_d   = latch_q;
      cnt_d     = cnt_q;
      start_d   = start_q;
      runmode_d = runmode_q;
      inmode_d  = inmode_q;
      irq_d     = irq_q;
      uf_d      = uf_q;
      dout_d    = dout_q;

      wr = sel && we;
      rd = sel && !we;
      // Tick qualification uses the control bits as they were before any
      // write in this cycle.
      tick       = start_q && (inmode_q ? cnt_in : eclk_tick);
      uf         = tick && (cnt_q == 16'h0000);
      thi_wr     = wr && (addr == A_THI);
      // THI loads the counter when stopped, or always in one-shot mode.
      thi_load   = thi_wr && (!start_q || runmode_q);
      force_load = thi_load || (wr && (addr == A_CTRL) && din[4]);

      if (clk7_en) begin
         uf_d = uf;

         // Reload on underflow uses latch_q, i.e. before a same-cycle TLO write.
         if (force_load)
            cnt_d = thi_load ? {din, latch_q[7:0]} : latch_q;
         else if (uf)
            cnt_d = latch_q;
         else if (tick)
            cnt_d = cnt_q - 16'd1;

         if (wr && (addr == A_TLO)) latch_d[7:0]  = din;
         if (thi_wr)                latch_d[15:8] = din;

         if (wr && (addr == A_CTRL)) begin
            start_d   = din[0];
            runmode_d = din[3];
            inmode_d  = din[5];
         end else if (thi_wr && runmode_q) begin
            start_d = 1'b1;
         end else if (uf && runmode_q) begin
            start_d = 1'b0;
         end

         // Underflow set wins over the ICR read clear.
         if (uf)
            irq_d = 1'b1;
         else if (rd && (addr == A_ICR))
            irq_d = 1'b0;

         if (rd) begin
            unique case (addr)
               A_TLO:   dout_d = cnt_q[7:0];
               A_THI:   dout_d = cnt_q[15:8];
               A_CTRL:  dout_d = {2'b00, inmode_q, 1'b0, runmode_q, 2'b00, start_q};
               default: dout_d = {7'b0, irq_q};
            endcase
         end
      end
   end

   always_ff @(posedge clk_28) begin
      if (rst) begin
         latch_q   <= RESET_LATCH;
         cnt_q     <= RESET_LATCH;
         start_q   <= 1'b0;
         runmode_q <= 1'b0;
         inmode_q  <= 1'b0;
         irq_q     <= 1'b0;
         uf_q      <= 1'b0;
         dout_q    <= 8'h00;
      end else begin
         latch_q   <= latch_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         runmode_q <= runmode_d;
         inmode_q  <= inmode_d;
         irq_q     <= irq_d;
         uf_q      <= uf_d;
         dout_q    <= dout_d;
      end
   end

   assign dout     = dout_q;
   assign irq      = irq_q;
   assign uf_pulse = uf_q;

endmodule

// File: tb/tb_cia_interval_timer.sv
module tb_cia_interval_timer;

   logic       clk_28 = 1'b0;
   logic       rst = 1'b1;
   logic       clk7_en = 1'b0;
   logic       eclk_tick = 1'b0;
   logic       cnt_in = 1'b0;
   logic       sel = 1'b0;
   logic       we = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       irq;
   logic       uf_pulse;

   int total = 0;
   int bad = 0;

   // uf_pulse width monitor: counts clk_28 cycles per pulse
   int run_w = 0;
   int last_w = 0;
   int uf_count = 0;

   cia_interval_timer #(.RESET_LATCH(16'hFFFF)) dut (
      .clk_28(clk_28), .rst(rst), .clk7_en(clk7_en), .eclk_tick(eclk_tick),
      .cnt_in(cnt_in), .sel(sel), .we(we), .addr(addr), .din(din),
      .dout(dout), .irq(irq), .uf_pulse(uf_pulse)
   );

   always #5 clk_28 = ~clk_28;

   always @(negedge clk_28) begin
      if (uf_pulse === 1'b1) begin
         run_w = run_w + 1;
      end else if (run_w != 0) begin
         last_w = run_w;
         run_w = 0;
         uf_count = uf_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Three idle clk_28 cycles, then one active cycle with the given inputs.
   // Returns #1 after the active edge.
   task automatic step(input logic s, input logic w, input logic [1:0] a,
                       input logic [7:0] d, input logic e, input logic c);
      repeat (3) @(posedge clk_28);
      #1;
      sel = s; we = w; addr = a; din = d; eclk_tick = e; cnt_in = c; clk7_en = 1'b1;
      @(posedge clk_28);
      #1;
      sel = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
      eclk_tick = 1'b0; cnt_in = 1'b0; clk7_en = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      step(1'b1, 1'b1, a, d, 1'b0, 1'b0);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      step(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0);
      chk(tag, {8'h00, dout}, {8'h00, exp});
   endtask

   task automatic etick();
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic ctick();
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
   endtask

   initial begin
      // reset
      repeat (2) @(posedge clk_28);
      #1 rst = 1'b0;
      chk("rst_dout", {8'h00, dout}, 16'h0000);
      chk("rst_irq", {15'h0, irq}, 16'h0000);
      chk("rst_uf", {15'h0, uf_pulse}, 16'h0000);
      rd_chk("rst_tlo", 2'd0, 8'hFF);
      rd_chk("rst_thi", 2'd1, 8'hFF);
      rd_chk("rst_ctrl", 2'd2, 8'h00);
      rd_chk("rst_icr", 2'd3, 8'h00);

      // continuous mode, latch 0003: underflows on ticks 4 and 8
      wr(2'd0, 8'h03);
      wr(2'd1, 8'h00);
      rd_chk("cont_load_tlo", 2'd0, 8'h03);
      wr(2'd2, 8'h01);
      for (int i = 1; i <= 10; i++) begin
         etick();
         chk($sformatf("cont_uf_t%0d", i), {15'h0, uf_pulse},
             {15'h0, ((i == 4) || (i == 8)) ? 1'b1 : 1'b0});
      end
      chk("cont_uf_count", uf_count[15:0], 16'd2);
      chk("cont_uf_width", last_w[15:0], 16'd4);
      chk("cont_irq", {15'h0, irq}, 16'h0001);
      rd_chk("cont_ctrl", 2'd2, 8'h01);
      rd_chk("cont_tlo", 2'd0, 8'h01);
      rd_chk("cont_thi", 2'd1, 8'h00);
      rd_chk("cont_icr", 2'd3, 8'h01);
      chk("cont_irq_clr", {15'h0, irq}, 16'h0000);

      // one-shot, latch 0002
      wr(2'd2, 8'h08);
      wr(2'd0, 8'h02);
      wr(2'd1, 8'h00);
      rd_chk("os_ctrl_started", 2'd2, 8'h09);
      for (int i = 1; i <= 6; i++) begin
         etick();
         chk($sformatf("os_uf_t%0d", i), {15'h0, uf_pulse},
             {15'h0, (i == 3) ? 1'b1 : 1'b0});
      end
      chk("os_uf_count", uf_count[15:0], 16'd3);
      rd_chk("os_ctrl_stopped", 2'd2, 8'h08);
      rd_chk("os_tlo", 2'd0, 8'h02);
      rd_chk("os_thi", 2'd1, 8'h00);
      rd_chk("os_icr", 2'd3, 8'h01);

      // INMODE: latch 0001, count cnt_in only
      wr(2'd0, 8'h01);
      wr(2'd1, 8'h00);
      wr(2'd2, 8'h21);
      for (int i = 0; i < 5; i++) etick();
      rd_chk("inm_no_eclk", 2'd0, 8'h01);
      chk("inm_no_uf", {15'h0, irq}, 16'h0000);
      ctick();
      chk("inm_c1_uf", {15'h0, uf_pulse}, 16'h0000);
      ctick();
      chk("inm_c2_uf", {15'h0, uf_pulse}, 16'h0001);
      rd_chk("inm_reload", 2'd0, 8'h01);
      rd_chk("inm_icr", 2'd3, 8'h01);

      // ICR read coinciding with an underflow
      ctick();
      step(1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 1'b1);
      chk("co_icr_dout", {8'h00, dout}, 16'h0000);
      chk("co_icr_irq", {15'h0, irq}, 16'h0001);
      rd_chk("co_icr_again", 2'd3, 8'h01);
      chk("co_icr_clr", {15'h0, irq}, 16'h0000);

      // LOAD strobe coinciding with a tick
      wr(2'd0, 8'h34);
      wr(2'd1, 8'h12);
      rd_chk("co_thi_noload", 2'd1, 8'h00);
      step(1'b1, 1'b1, 2'd2, 8'h31, 1'b0, 1'b1);
      rd_chk("co_load_tlo", 2'd0, 8'h34);
      rd_chk("co_load_thi", 2'd1, 8'h12);
      rd_chk("co_load_ctrl", 2'd2, 8'h21);

      // reset mid-count in an idle cycle
      wr(2'd2, 8'h00);
      wr(2'd0, 8'h05);
      wr(2'd1, 8'h00);
      wr(2'd2, 8'h01);
      rd_chk("mid_pre_tlo", 2'd0, 8'h05);
      @(posedge clk_28);
      #1 rst = 1'b1;
      @(posedge clk_28);
      #1 rst = 1'b0;
      chk("mid_uf", {15'h0, uf_pulse}, 16'h0000);
      rd_chk("mid_tlo", 2'd0, 8'hFF);
      rd_chk("mid_thi", 2'd1, 8'hFF);
      rd_chk("mid_ctrl", 2'd2, 8'h00);
      for (int i = 0; i < 6; i++) begin
         etick();
         chk($sformatf("mid_no_uf%0d", i), {15'h0, uf_pulse}, 16'h0000);
      end
      rd_chk("mid_hold", 2'd0, 8'hFF);
      chk("mid_irq", {15'h0, irq}, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
